// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the MEM/WB stage, the MDU and the register-file write port.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline.
interface wb_port_arbiter_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_BITS = 5
);
    logic                wb_regwrite;
    logic                wb_memtoreg;
    logic [XLEN-1:0]     wb_read_data;
    logic [XLEN-1:0]     wb_alu_result;
    logic [REG_BITS-1:0] wb_write_reg;
    logic                mdu_valid;
    logic                mdu_ready;
    logic [XLEN-1:0]     mdu_result;
    logic [REG_BITS-1:0] mdu_rd;
    logic                wb_stall;
    logic                rf_we;
    logic [REG_BITS-1:0] rf_waddr;
    logic [XLEN-1:0]     rf_wdata;
    logic                pend_valid;
    logic [REG_BITS-1:0] pend_rd;

    modport slave (
        input  wb_regwrite, wb_memtoreg, wb_read_data, wb_alu_result, wb_write_reg,
        input  mdu_valid, mdu_result, mdu_rd,
        output mdu_ready, wb_stall, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd
    );

    modport master (
        output wb_regwrite, wb_memtoreg, wb_read_data, wb_alu_result, wb_write_reg,
        output mdu_valid, mdu_result, mdu_rd,
        input  mdu_ready, wb_stall, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and the MDU.
// The pipeline has priority; a 1-entry buffer holds MDU results and forces a drain after MAX_WAIT.
module wb_port_arbiter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    wb_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FORCE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     buf_data_q, buf_data_d;
    logic [REG_BITS-1:0] buf_rd_q, buf_rd_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic                pipe_req_c;
    logic [XLEN-1:0]     pipe_wdata_c;
    logic                mdu_ready_c, wb_stall_c, pend_valid_c, rf_we_c;
    logic [REG_BITS-1:0] rf_waddr_c;
    logic [XLEN-1:0]     rf_wdata_c;

    assign pipe_req_c   = bus.wb_regwrite && (bus.wb_write_reg != '0);
    assign pipe_wdata_c = bus.wb_memtoreg ? bus.wb_read_data : bus.wb_alu_result;

    // Next state and port mux; reset blanks every output regardless of state.
    always_comb begin
        state_d      = state_q;
        buf_data_d   = buf_data_q;
        buf_rd_d     = buf_rd_q;
        wait_cnt_d   = wait_cnt_q;
        mdu_ready_c  = 1'b0;
        wb_stall_c   = 1'b0;
        pend_valid_c = 1'b0;
        rf_we_c      = pipe_req_c;
        rf_waddr_c   = bus.wb_write_reg;
        rf_wdata_c   = pipe_wdata_c;

        unique case (state_q)
            IDLE: begin
                mdu_ready_c = 1'b1;
                if (bus.mdu_valid && (bus.mdu_rd != '0)) begin
                    buf_data_d = bus.mdu_result;
                    buf_rd_d   = bus.mdu_rd;
                    wait_cnt_d = '0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                pend_valid_c = 1'b1;
                if (!pipe_req_c) begin
                    rf_we_c    = 1'b1;
                    rf_waddr_c = buf_rd_q;
                    rf_wdata_c = buf_data_q;
                    buf_data_d = '0;
                    buf_rd_d   = '0;
                    wait_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (wait_cnt_q == LAST_WAIT) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                pend_valid_c = 1'b1;
                wb_stall_c   = 1'b1;
                rf_we_c      = 1'b1;
                rf_waddr_c   = buf_rd_q;
                rf_wdata_c   = buf_data_q;
                buf_data_d   = '0;
                buf_rd_d     = '0;
                wait_cnt_d   = '0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset_i) begin
            mdu_ready_c  = 1'b0;
            wb_stall_c   = 1'b0;
            pend_valid_c = 1'b0;
            rf_we_c      = 1'b0;
            rf_waddr_c   = '0;
            rf_wdata_c   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            buf_data_q <= '0;
            buf_rd_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_data_q <= buf_data_d;
            buf_rd_q   <= buf_rd_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.mdu_ready  = mdu_ready_c;
    assign bus.wb_stall   = wb_stall_c;
    assign bus.pend_valid = pend_valid_c;
    assign bus.pend_rd    = pend_valid_c ? buf_rd_q : '0;
    assign bus.rf_we      = rf_we_c;
    assign bus.rf_waddr   = rf_waddr_c;
    assign bus.rf_wdata   = rf_wdata_c;
endmodule
